// File: rtl/axi_wr_router.sv
// AXI4 write-slave front end: routes burst beats into per-channel FIFOs with per-channel index counters.
// Define WR_ROUTER_WLAST_CHECK_EN to flag bursts whose wlast disagrees with awlen as SLVERR.
module axi_wr_router #(
   parameter int DATA_W = 32,
   parameter int ID_W   = 4,
   parameter int NUM_CH = 2,
   parameter int IDX_W  = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ID_W-1:0]     axs_s0_awid,
   input  logic [31:0]         axs_s0_awaddr,
   input  logic [7:0]          axs_s0_awlen,
   input  logic [2:0]          axs_s0_awsize,
   input  logic [1:0]          axs_s0_awburst,
   input  logic                axs_s0_awvalid,
   output logic                axs_s0_awready,
   input  logic [DATA_W-1:0]   axs_s0_wdata,
   input  logic [DATA_W/8-1:0] axs_s0_wstrb,
   input  logic                axs_s0_wlast,
   input  logic                axs_s0_wvalid,
   output logic                axs_s0_wready,
   output logic [ID_W-1:0]     axs_s0_bid,
   output logic [1:0]          axs_s0_bresp,
   output logic                axs_s0_bvalid,
   input  logic                axs_s0_bready,
   input  logic [NUM_CH-1:0]   ch_full,
   output logic [NUM_CH-1:0]   ch_clr,
   output logic [NUM_CH-1:0]   ch_push,
   output logic [DATA_W-1:0]   ch_wdata,
   output logic [DATA_W/8-1:0] ch_wstrb,
   output logic [IDX_W-1:0]    ch_index,
   output logic                ch_last
);

   typedef enum logic [1:0] {INIT, IDLE, DATA, RESP} state_t;

   localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

   state_t           state_q, state_d;
   logic [3:0]       sel_q, sel_d;
   logic             close_q, close_d;
   logic             mapped_q, mapped_d;
   logic             err_q, err_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q [NUM_CH];
   logic [IDX_W-1:0] idx_d [NUM_CH];

   logic             full_sel;
   logic [IDX_W-1:0] idx_sel;
   logic             beat;
   logic             last_beat;
   logic             unused_ok;

   assign unused_ok = ^{axs_s0_awaddr[31:8], axs_s0_awaddr[3:1], axs_s0_awsize,
                        axs_s0_awburst, axs_s0_wlast};

   always_comb begin
      full_sel = 1'b0;
      idx_sel  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_q == 4'(i)) begin
            full_sel = ch_full[i];
            idx_sel  = idx_q[i];
         end
      end
   end

   // Error bursts drain freely since nothing is pushed for them.
   assign axs_s0_awready = (state_q == IDLE);
   assign axs_s0_wready  = (state_q == DATA) && (!mapped_q || !full_sel);
   assign beat           = axs_s0_wvalid && axs_s0_wready;
   assign last_beat      = beat && (cnt_q == 8'd0);

   assign axs_s0_bvalid = (state_q == RESP);
   assign axs_s0_bid    = axs_s0_bvalid ? id_q : '0;
   assign axs_s0_bresp  = axs_s0_bvalid ? {err_q, 1'b0} : 2'b00;

   assign ch_clr   = {NUM_CH{state_q == INIT}};
   assign ch_wdata = axs_s0_wdata;
   assign ch_wstrb = axs_s0_wstrb;
   assign ch_index = mapped_q ? idx_sel : '0;
   assign ch_last  = last_beat && close_q && mapped_q;

   always_comb begin
      ch_push = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_push[i] = beat && mapped_q && (sel_q == 4'(i));
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      close_d  = close_q;
      mapped_d = mapped_q;
      err_d    = err_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      case (state_q)
         INIT: state_d = IDLE;
         IDLE: begin
            if (axs_s0_awvalid) begin
               state_d  = DATA;
               sel_d    = axs_s0_awaddr[7:4];
               close_d  = axs_s0_awaddr[0];
               mapped_d = ({1'b0, axs_s0_awaddr[7:4]} < NUM_CH_L);
               err_d    = !({1'b0, axs_s0_awaddr[7:4]} < NUM_CH_L);
               id_d     = axs_s0_awid;
               cnt_d    = axs_s0_awlen;
            end
         end
         DATA: begin
            if (beat) begin
               cnt_d = cnt_q - 8'd1;
`ifdef WR_ROUTER_WLAST_CHECK_EN
               if (axs_s0_wlast != (cnt_q == 8'd0)) begin
                  err_d = 1'b1;
               end
`endif
            end
            if (last_beat) begin
               state_d = RESP;
               for (int i = 0; i < NUM_CH; i++) begin
                  if (close_q && mapped_q && (sel_q == 4'(i))) begin
                     idx_d[i] = idx_q[i] + IDX_W'(1);
                  end
               end
            end
         end
         RESP: begin
            if (axs_s0_bready) begin
               state_d = IDLE;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= INIT;
         sel_q    <= '0;
         close_q  <= 1'b0;
         mapped_q <= 1'b0;
         err_q    <= 1'b0;
         id_q     <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            idx_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         close_q  <= close_d;
         mapped_q <= mapped_d;
         err_q    <= err_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
      end
   end

endmodule

// File: doc/axi_wr_router.md
# axi_wr_router

Parametrised AXI4 write-slave front end that decodes the write address into one of `NUM_CH` input channels and streams every accepted data beat, with its strobe and a per-channel index, into that channel's FIFO. Replaces the fixed two-channel single-beat write FSM: it adds multi-beat INCR/FIXED bursts, configurable data/ID/index widths, per-channel index counters and SLVERR responses for unmapped channels. It sits between the AXI interconnect and the per-channel input FIFOs of the decoder datapath.

## Interface
- `DATA_W`, 32: write data width; multiple of 8.
- `ID_W`, 4: AXI ID width.
- `NUM_CH`, 2: number of channels, 1..16.
- `IDX_W`, 10: per-channel index counter width.
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `axs_s0_awid`/`awaddr`/`awlen`/`awsize`/`awburst`  in  ID_W/32/8/3/2  AW channel.
- `axs_s0_awvalid` in 1, `axs_s0_awready` out 1.
- `axs_s0_wdata`/`wstrb`/`wlast`  in  DATA_W/DATA_W/8/1  W channel.
- `axs_s0_wvalid` in 1, `axs_s0_wready` out 1.
- `axs_s0_bid`/`bresp`/`bvalid`  out  ID_W/2/1; `axs_s0_bready` in 1.
- `ch_full`  in  NUM_CH  per-channel FIFO full.
- `ch_clr`  out  NUM_CH  per-channel FIFO/index clear.
- `ch_push`  out  NUM_CH  one-hot beat push strobe.
- `ch_wdata`  out  DATA_W  beat data, valid with `ch_push`.
- `ch_wstrb`  out  DATA_W/8  beat strobe.
- `ch_index`  out  IDX_W  index of the selected channel, pre-increment.
- `ch_last`  out  1  high with the final push of an index-closing burst.

## Operation
- Decode on AW handshake: `sel = awaddr[7:4]`, `close = awaddr[0]`; `sel >= NUM_CH` → error burst. `awid`, `awlen`, `sel`, `close` latched.
- States: INIT → IDLE → DATA → RESP → IDLE.
- INIT: held during reset and for exactly one cycle after release; `ch_clr` all-ones, all ready/valid low; index counters zero.
- IDLE: `awready=1`; on `awvalid` go DATA, beat counter = `awlen`.
- DATA: `wready = ~ch_full[sel]` (combinational; error burst: `wready=1`). Beat accepted on `wvalid & wready`; `ch_push[sel] = wvalid & wready` same cycle (never for error bursts), `ch_wdata/ch_wstrb` pass through `wdata/wstrb`. After beat `awlen+1` → RESP.
- Index: on the final beat of a `close` burst `ch_last=1`, and `index[sel]` increments after the push; `2^IDX_W-1` wraps to 0. Non-close bursts leave the index unchanged.
- RESP: `bvalid=1`, `bid` = latched ID, `bresp` = 2'b00 OKAY or 2'b10 SLVERR (unmapped, or wlast error). Held stable until `bready`; go IDLE.
- `awburst`/`awsize` ignored; FIXED and INCR behave identically; beats narrower than DATA_W are conveyed by `wstrb` only.
- Only one outstanding transaction; no AW accepted outside IDLE.

## Timing
- Reset values: `awready=0`, `wready=0`, `bvalid=0`, `bid=0`, `bresp=0`, `ch_push=0`, `ch_last=0`, `ch_clr` all-ones.
- AW handshake at cycle t → `wready` earliest t+1; last beat at t' → `bvalid` at t'+1; B handshake at t'' → `awready` at t''+1.
- `ch_full` rising mid-burst drops `wready` the same cycle; no beat is pushed into a full FIFO.
- `ch_full` on the selected channel does not affect other channels or AW acceptance in IDLE.
- `reset_n` low mid-burst: burst abandoned, no B response issued, counters cleared, INIT re-entered.
- `ch_clr` is asserted only in INIT.

## Configuration
- `WR_ROUTER_WLAST_CHECK_EN` defined: `wlast` high before the final beat, or low on it, marks the burst SLVERR. Beat counting still follows `awlen`, and the beats are still pushed.
- Undefined: `wlast` ignored; `bresp` is SLVERR only for unmapped channels.

## Test plan
- Reset, release → `ch_clr`=2'b11 for 1 cycle after release, then `awready=1`; all other outputs 0.
- AW `awaddr=0x01`, `awlen=3`, `awid=5`, 4 beats 0xA0..0xA3 → `ch_push[0]` ×4 with data A0..A3, `ch_index=0`; `ch_last` only on A3; `bid=5`, `bresp=0`; next burst to ch0 shows `ch_index=1`.
- Burst to `awaddr=0x10`, `awlen=1`, with `ch_full[1]` high for 3 cycles mid-burst → `wready` low those 3 cycles; exactly 2 pushes; OKAY.
- `awaddr=0x70` with `NUM_CH=2`, `awlen=2` → 3 beats accepted, no `ch_push`, `bresp=2'b10`.
- Force ch0 index to 1023 via 1023 close bursts, then one more close burst → `ch_index=1023` on its push, then 0.
- With the macro defined, `awlen=1` and `wlast` high on beat 0 → SLVERR; `bready` held low 4 cycles → `bvalid`/`bresp` stable; reset mid-burst → no `bvalid`.
